// File: rtl/fp_flopoco_pkg.sv
// Shared definitions for FloPoCo-format floats {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
// Provides exception codes, comparator op codes and field-offset helpers.
package fp_flopoco_pkg;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  localparam logic [1:0] CMP_LT = 2'b00;
  localparam logic [1:0] CMP_LE = 2'b01;
  localparam logic [1:0] CMP_EQ = 2'b10;
  localparam logic [1:0] CMP_UN = 2'b11;

  function automatic int fp_width(input int we, input int wf);
    return we + wf + 3;
  endfunction

  function automatic int fp_exc_lsb(input int we, input int wf);
    return we + wf + 1;
  endfunction

  function automatic int fp_sign_bit(input int we, input int wf);
    return we + wf;
  endfunction

  function automatic int fp_exp_lsb(input int wf);
    return wf;
  endfunction

  // Magnitude key: one guard bit above {1,exp,frac} so the largest normal
  // still orders strictly below infinity (all-ones).
  function automatic int fp_key_width(input int we, input int wf);
    return we + wf + 2;
  endfunction

endpackage

// File: rtl/fp_compare_pipe_if.sv
// Operand/result bus for fp_compare_pipe.
// Optional min/max result signals exist only when FPCMP_MINMAX_EN is defined.
interface fp_compare_pipe_if #(
  parameter int WE   = 11,
  parameter int WF   = 9,
  parameter int TAGW = 4
);
  localparam int W = WE + WF + 3;

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic [1:0]      in_op;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic            out_res;
  logic            out_lt;
  logic            out_eq;
  logic            out_gt;
  logic            out_unord;
  logic [TAGW-1:0] out_tag;
`ifdef FPCMP_MINMAX_EN
  logic [W-1:0]    out_min;
  logic [W-1:0]    out_max;

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_lt, out_eq, out_gt, out_unord, out_tag,
    input  out_min, out_max
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_lt, out_eq, out_gt, out_unord, out_tag,
    output out_min, out_max
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_lt, out_eq, out_gt, out_unord, out_tag
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_lt, out_eq, out_gt, out_unord, out_tag
  );
`endif
endinterface

// File: rtl/fp_cmp_classify.sv
// Combinational operand classifier (stage 1 of fp_compare_pipe).
// Decodes the exception field and builds an unsigned magnitude key:
// zero -> 0, normal -> {0,1,exp,frac}, inf -> all-ones.
module fp_cmp_classify
  import fp_flopoco_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 9
) (
  input  logic [WE+WF+2:0] x_i,
  output logic             is_nan_o,
  output logic             is_zero_o,
  output logic             sign_o,
  output logic [WE+WF+1:0] key_o
);
  localparam int EXC_LSB  = fp_exc_lsb(WE, WF);
  localparam int SIGN_BIT = fp_sign_bit(WE, WF);
  localparam int EXP_LSB  = fp_exp_lsb(WF);

  logic [1:0] exc;

  assign exc       = x_i[EXC_LSB +: 2];
  assign is_nan_o  = (exc == EXC_NAN);
  assign is_zero_o = (exc == EXC_ZERO);
  assign sign_o    = x_i[SIGN_BIT];

  // Map the exception class onto a monotonic magnitude key
  always_comb begin
    key_o = '0;
    unique case (exc)
      EXC_ZERO: key_o = '0;
      EXC_NORM: key_o = {1'b0, 1'b1, x_i[EXP_LSB +: WE], x_i[WF-1:0]};
      EXC_INF:  key_o = '1;
      default:  key_o = '0;
    endcase
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// Three-stage pipelined FloPoCo float comparator with valid/ready flow control.
// S1 classifies operands, S2 compares magnitude keys, S3 resolves signs and
// selects the op result. Optional macro FPCMP_MINMAX_EN adds out_min/out_max.
module fp_compare_pipe
  import fp_flopoco_pkg::*;
#(
  parameter int WE   = 11,
  parameter int WF   = 9,
  parameter int TAGW = 4
) (
  input logic             clk,
  input logic             rst,
  fp_compare_pipe_if.slave cmp_if
);
  localparam int W  = fp_width(WE, WF);
  localparam int KW = fp_key_width(WE, WF);

  // Load-enable chain: a stage loads when empty or when its successor loads
  logic ld1, ld2, ld3;

  // Stage-valid control
  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic out_valid_q, out_valid_d;

  // S1 data
  logic            nan_a_p1_q, nan_b_p1_q, zero_a_p1_q, zero_b_p1_q;
  logic            sgn_a_p1_q, sgn_b_p1_q;
  logic [KW-1:0]   key_a_p1_q, key_b_p1_q;
  logic [1:0]      op_p1_q;
  logic [TAGW-1:0] tag_p1_q;

  // S2 data
  logic            any_nan_p2_q, both_zero_p2_q;
  logic            sgn_a_p2_q, sgn_b_p2_q;
  logic            mag_lt_p2_q, mag_eq_p2_q;
  logic [1:0]      op_p2_q;
  logic [TAGW-1:0] tag_p2_q;

  // S3 (output) registers and their next state
  logic            res_q, lt_q, eq_q, gt_q, un_q;
  logic            res_d, lt_d, eq_d, gt_d, un_d;
  logic [TAGW-1:0] tag_q;

  // Classifier outputs
  logic          cls_nan_a, cls_zero_a, cls_sgn_a;
  logic          cls_nan_b, cls_zero_b, cls_sgn_b;
  logic [KW-1:0] cls_key_a, cls_key_b;

`ifdef FPCMP_MINMAX_EN
  logic [W-1:0] a_p1_q, b_p1_q, a_p2_q, b_p2_q;
  logic         nan_a_p2_q, nan_b_p2_q;
  logic [W-1:0] min_q, max_q, min_d, max_d;
`endif

  assign ld3 = !out_valid_q || cmp_if.out_ready;
  assign ld2 = !vld_p2_q || ld3;
  assign ld1 = !vld_p1_q || ld2;

  assign cmp_if.in_ready  = ld1 && !rst;
  assign cmp_if.out_valid = out_valid_q;
  assign cmp_if.out_res   = res_q;
  assign cmp_if.out_lt    = lt_q;
  assign cmp_if.out_eq    = eq_q;
  assign cmp_if.out_gt    = gt_q;
  assign cmp_if.out_unord = un_q;
  assign cmp_if.out_tag   = tag_q;
`ifdef FPCMP_MINMAX_EN
  assign cmp_if.out_min   = min_q;
  assign cmp_if.out_max   = max_q;
`endif

  fp_cmp_classify #(.WE(WE), .WF(WF)) u_cls_a (
    .x_i      (cmp_if.in_a),
    .is_nan_o (cls_nan_a),
    .is_zero_o(cls_zero_a),
    .sign_o   (cls_sgn_a),
    .key_o    (cls_key_a)
  );

  fp_cmp_classify #(.WE(WE), .WF(WF)) u_cls_b (
    .x_i      (cmp_if.in_b),
    .is_nan_o (cls_nan_b),
    .is_zero_o(cls_zero_b),
    .sign_o   (cls_sgn_b),
    .key_o    (cls_key_b)
  );

  // Next-state of the stage-valid bits; a stage holds when not loading
  always_comb begin
    vld_p1_d    = ld1 ? cmp_if.in_valid : vld_p1_q;
    vld_p2_d    = ld2 ? vld_p1_q        : vld_p2_q;
    out_valid_d = ld3 ? vld_p2_q        : out_valid_q;
  end

  // Stage-valid registers, cleared asynchronously so in-flight ops are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---- S1: classified operands ----
  // Capture classifier results when S1 loads
  always_ff @(posedge clk) begin
    if (ld1) begin
      nan_a_p1_q  <= cls_nan_a;
      nan_b_p1_q  <= cls_nan_b;
      zero_a_p1_q <= cls_zero_a;
      zero_b_p1_q <= cls_zero_b;
      sgn_a_p1_q  <= cls_sgn_a;
      sgn_b_p1_q  <= cls_sgn_b;
      key_a_p1_q  <= cls_key_a;
      key_b_p1_q  <= cls_key_b;
      op_p1_q     <= cmp_if.in_op;
      tag_p1_q    <= cmp_if.in_tag;
`ifdef FPCMP_MINMAX_EN
      a_p1_q      <= cmp_if.in_a;
      b_p1_q      <= cmp_if.in_b;
`endif
    end
  end

  // ---- S2: magnitude comparison ----
  // Compare keys and reduce the exception info to what S3 needs
  always_ff @(posedge clk) begin
    if (ld2) begin
      any_nan_p2_q   <= nan_a_p1_q || nan_b_p1_q;
      both_zero_p2_q <= zero_a_p1_q && zero_b_p1_q;
      sgn_a_p2_q     <= sgn_a_p1_q;
      sgn_b_p2_q     <= sgn_b_p1_q;
      mag_lt_p2_q    <= key_a_p1_q < key_b_p1_q;
      mag_eq_p2_q    <= key_a_p1_q == key_b_p1_q;
      op_p2_q        <= op_p1_q;
      tag_p2_q       <= tag_p1_q;
`ifdef FPCMP_MINMAX_EN
      a_p2_q         <= a_p1_q;
      b_p2_q         <= b_p1_q;
      nan_a_p2_q     <= nan_a_p1_q;
      nan_b_p2_q     <= nan_b_p1_q;
`endif
    end
  end

  // ---- S3: sign resolution, flags and op result ----
  // Resolve signs into one-hot lt/eq/gt/unord, then pick the op result
  always_comb begin
    lt_d  = 1'b0;
    eq_d  = 1'b0;
    gt_d  = 1'b0;
    un_d  = 1'b0;
    res_d = 1'b0;
    if (any_nan_p2_q) begin
      un_d = 1'b1;
    end else if (both_zero_p2_q) begin
      eq_d = 1'b1;
    end else if (sgn_a_p2_q != sgn_b_p2_q) begin
      lt_d = sgn_a_p2_q;
      gt_d = !sgn_a_p2_q;
    end else if (!sgn_a_p2_q) begin
      lt_d = mag_lt_p2_q;
      eq_d = mag_eq_p2_q;
      gt_d = !mag_lt_p2_q && !mag_eq_p2_q;
    end else begin
      lt_d = !mag_lt_p2_q && !mag_eq_p2_q;
      eq_d = mag_eq_p2_q;
      gt_d = mag_lt_p2_q;
    end
    unique case (op_p2_q)
      CMP_LT:  res_d = lt_d;
      CMP_LE:  res_d = lt_d || eq_d;
      CMP_EQ:  res_d = eq_d;
      default: res_d = un_d;
    endcase
  end

`ifdef FPCMP_MINMAX_EN
  // Min/max selection: NaN yields the other operand, ties and double NaN yield A
  always_comb begin
    min_d = a_p2_q;
    max_d = a_p2_q;
    if (nan_a_p2_q && !nan_b_p2_q) begin
      min_d = b_p2_q;
      max_d = b_p2_q;
    end else if (!nan_a_p2_q && !nan_b_p2_q) begin
      min_d = gt_d ? b_p2_q : a_p2_q;
      max_d = lt_d ? b_p2_q : a_p2_q;
    end
  end
`endif

  // Output registers; they hold while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      gt_q  <= 1'b0;
      un_q  <= 1'b0;
      tag_q <= '0;
`ifdef FPCMP_MINMAX_EN
      min_q <= '0;
      max_q <= '0;
`endif
    end else if (ld3) begin
      res_q <= res_d;
      lt_q  <= lt_d;
      eq_q  <= eq_d;
      gt_q  <= gt_d;
      un_q  <= un_d;
      tag_q <= tag_p2_q;
`ifdef FPCMP_MINMAX_EN
      min_q <= min_d;
      max_q <= max_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed testbench for fp_compare_pipe (WE=11, WF=9, TAGW=4).
module tb_fp_compare_pipe;
  localparam int WE   = 11;
  localparam int WF   = 9;
  localparam int TAGW = 4;
  localparam int W    = WE + WF + 3;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  // Captured result of the last single operation
  logic            r_res, r_lt, r_eq, r_gt, r_un;
  logic [TAGW-1:0] r_tag;
  int              r_lat;
`ifdef FPCMP_MINMAX_EN
  logic [W-1:0]    r_min, r_max;
`endif

  fp_compare_pipe_if #(.WE(WE), .WF(WF), .TAGW(TAGW)) cmp_if ();

  fp_compare_pipe #(.WE(WE), .WF(WF), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst   (rst),
    .cmp_if(cmp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [1:0] e, input logic s,
                                      input logic [WE-1:0] ex, input logic [WF-1:0] f);
    return {e, s, ex, f};
  endfunction

  logic [W-1:0] P1, P2, N1, N2, N3, PZ, NZ, NAN, PINF, NINF;

  // Apply one op on an otherwise idle pipe and capture its result
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic [TAGW-1:0] tag);
    int n;
    logic got;
    @(negedge clk);
    cmp_if.out_ready = 1'b1;
    cmp_if.in_a      = a;
    cmp_if.in_b      = b;
    cmp_if.in_op     = op;
    cmp_if.in_tag    = tag;
    cmp_if.in_valid  = 1'b1;
    #1;
    n = 0;
    while (!cmp_if.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL accept_timeout tag=%0d in_ready=%b required=1", tag, cmp_if.in_ready);
    end
    @(posedge clk);
    #1 cmp_if.in_valid = 1'b0;
    got = 1'b0;
    r_lat = 0;
    while (!got && r_lat < 10) begin
      @(negedge clk);
      r_lat++;
      if (cmp_if.out_valid) begin
        got   = 1'b1;
        r_res = cmp_if.out_res;
        r_lt  = cmp_if.out_lt;
        r_eq  = cmp_if.out_eq;
        r_gt  = cmp_if.out_gt;
        r_un  = cmp_if.out_unord;
        r_tag = cmp_if.out_tag;
`ifdef FPCMP_MINMAX_EN
        r_min = cmp_if.out_min;
        r_max = cmp_if.out_max;
`endif
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL result_timeout tag=%0d out_valid=0 required=1", tag);
    end
    checks++;
    if ((int'(r_lt) + int'(r_eq) + int'(r_gt) + int'(r_un)) != 1) begin
      errors++;
      $display("FAIL onehot tag=%0d lt/eq/gt/un=%b%b%b%b required exactly one set",
               tag, r_lt, r_eq, r_gt, r_un);
    end
    checks++;
    if (r_tag !== tag) begin
      errors++;
      $display("FAIL tag got=%0d required=%0d", r_tag, tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmp_if.in_valid  = 1'b1;
    cmp_if.out_ready = 1'b1;
    cmp_if.in_a = '0; cmp_if.in_b = '0; cmp_if.in_op = 2'b00; cmp_if.in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmp_if.out_valid !== 1'b0 || cmp_if.out_res !== 1'b0 || cmp_if.out_lt !== 1'b0 ||
        cmp_if.out_eq !== 1'b0 || cmp_if.out_gt !== 1'b0 || cmp_if.out_unord !== 1'b0 ||
        cmp_if.out_tag !== '0) begin
      errors++;
      $display("FAIL reset_outputs v=%b res=%b lt=%b eq=%b gt=%b un=%b tag=%0d required all 0",
               cmp_if.out_valid, cmp_if.out_res, cmp_if.out_lt, cmp_if.out_eq,
               cmp_if.out_gt, cmp_if.out_unord, cmp_if.out_tag);
    end
    checks++;
    if (cmp_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b required=0", cmp_if.in_ready);
    end
    cmp_if.in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmp_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_ghost out_valid=%b required=0", cmp_if.out_valid);
    end
  endtask

  task automatic test_basic;
    do_op(P1, P2, 2'b00, 4'd1);
    checks++;
    if (r_res !== 1'b1 || r_lt !== 1'b1) begin
      errors++;
      $display("FAIL basic_lt res=%b lt=%b required res=1 lt=1", r_res, r_lt);
    end
    checks++;
    if (r_lat != 3) begin
      errors++;
      $display("FAIL latency got=%0d required=3", r_lat);
    end
    do_op(P2, P1, 2'b00, 4'd2);
    checks++;
    if (r_res !== 1'b0 || r_gt !== 1'b1) begin
      errors++;
      $display("FAIL basic_gt res=%b gt=%b required res=0 gt=1", r_res, r_gt);
    end
    do_op(P1, P1, 2'b01, 4'd3);
    checks++;
    if (r_res !== 1'b1 || r_eq !== 1'b1) begin
      errors++;
      $display("FAIL basic_le res=%b eq=%b required res=1 eq=1", r_res, r_eq);
    end
  endtask

  task automatic test_zero;
    do_op(PZ, NZ, 2'b10, 4'd4);
    checks++;
    if (r_res !== 1'b1 || r_eq !== 1'b1) begin
      errors++;
      $display("FAIL zero_eq res=%b eq=%b required res=1 eq=1", r_res, r_eq);
    end
    do_op(PZ, NZ, 2'b00, 4'd5);
    checks++;
    if (r_res !== 1'b0) begin
      errors++;
      $display("FAIL zero_lt res=%b required=0", r_res);
    end
  endtask

  task automatic test_nan;
    for (int op = 0; op < 4; op++) begin
      do_op(NAN, P1, op[1:0], 4'(op + 6));
      checks++;
      if (r_un !== 1'b1 || r_res !== (op == 3) || r_lt !== 1'b0 || r_eq !== 1'b0 || r_gt !== 1'b0) begin
        errors++;
        $display("FAIL nan_op%0d res=%b un=%b lt=%b eq=%b gt=%b required res=%0d un=1 others 0",
                 op, r_res, r_un, r_lt, r_eq, r_gt, (op == 3));
      end
    end
  endtask

  task automatic test_negative;
    do_op(N2, N1, 2'b00, 4'd10);
    checks++;
    if (r_lt !== 1'b1 || r_res !== 1'b1) begin
      errors++;
      $display("FAIL neg_m2_m1 lt=%b res=%b required lt=1 res=1", r_lt, r_res);
    end
    do_op(NINF, N1, 2'b00, 4'd11);
    checks++;
    if (r_lt !== 1'b1) begin
      errors++;
      $display("FAIL neg_inf lt=%b required=1", r_lt);
    end
    do_op(PINF, PINF, 2'b10, 4'd12);
    checks++;
    if (r_eq !== 1'b1 || r_res !== 1'b1) begin
      errors++;
      $display("FAIL inf_eq eq=%b res=%b required eq=1 res=1", r_eq, r_res);
    end
    do_op(N1, P1, 2'b00, 4'd13);
    checks++;
    if (r_lt !== 1'b1) begin
      errors++;
      $display("FAIL mixed_sign lt=%b required=1", r_lt);
    end
  endtask

  task automatic test_back_to_back;
    int sent, got, first_block;
    logic held_v, held_res;
    logic [TAGW-1:0] held_tag;
    sent = 0; got = 0; first_block = -1; held_v = 1'b0;
    held_res = 1'b0; held_tag = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      cmp_if.out_ready = (cyc >= 5);
      if (sent < 8) begin
        cmp_if.in_valid = 1'b1;
        cmp_if.in_a     = sent[0] ? P2 : P1;
        cmp_if.in_b     = sent[0] ? P1 : P2;
        cmp_if.in_op    = 2'b00;
        cmp_if.in_tag   = 4'(sent);
      end else begin
        cmp_if.in_valid = 1'b0;
      end
      #1;
      if (cmp_if.out_valid) begin
        if (held_v) begin
          checks++;
          if (cmp_if.out_tag !== held_tag || cmp_if.out_res !== held_res) begin
            errors++;
            $display("FAIL stall_stable tag=%0d res=%b required tag=%0d res=%b",
                     cmp_if.out_tag, cmp_if.out_res, held_tag, held_res);
          end
        end
        if (cmp_if.out_ready) begin
          checks++;
          if (cmp_if.out_tag !== 4'(got) || cmp_if.out_res !== (got % 2 == 0)) begin
            errors++;
            $display("FAIL stream_result tag=%0d res=%b required tag=%0d res=%0d",
                     cmp_if.out_tag, cmp_if.out_res, got, (got % 2 == 0));
          end
          got++;
          held_v = 1'b0;
        end else begin
          held_v   = 1'b1;
          held_tag = cmp_if.out_tag;
          held_res = cmp_if.out_res;
        end
      end
      if (cmp_if.in_valid && !cmp_if.in_ready && first_block < 0) first_block = sent;
      if (cmp_if.in_valid && cmp_if.in_ready) sent++;
    end
    cmp_if.in_valid = 1'b0;
    checks++;
    if (first_block != 3) begin
      errors++;
      $display("FAIL stall_in_ready accepted_before_block=%0d required=3", first_block);
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL stream_count got=%0d required=8", got);
    end
    cmp_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rst_mid;
    int ghosts;
    @(negedge clk);
    cmp_if.out_ready = 1'b0;
    cmp_if.in_a = P1; cmp_if.in_b = P2; cmp_if.in_op = 2'b00; cmp_if.in_tag = 4'd9;
    cmp_if.in_valid = 1'b1;
    @(negedge clk);
    cmp_if.in_tag = 4'd10;
    @(negedge clk);
    cmp_if.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmp_if.out_valid !== 1'b1 || cmp_if.out_lt !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre out_valid=%b lt=%b required 1 1", cmp_if.out_valid, cmp_if.out_lt);
    end
    rst = 1'b1;
    cmp_if.in_valid = 1'b1;
    #1;
    checks++;
    if (cmp_if.out_valid !== 1'b0 || cmp_if.out_lt !== 1'b0 || cmp_if.out_res !== 1'b0 ||
        cmp_if.out_tag !== '0 || cmp_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async v=%b lt=%b res=%b tag=%0d in_ready=%b required all 0",
               cmp_if.out_valid, cmp_if.out_lt, cmp_if.out_res, cmp_if.out_tag, cmp_if.in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_if.in_valid  = 1'b0;
    cmp_if.out_ready = 1'b1;
    ghosts = 0;
    repeat (8) begin
      @(negedge clk);
      if (cmp_if.out_valid) ghosts++;
    end
    checks++;
    if (ghosts != 0) begin
      errors++;
      $display("FAIL rst_mid_stale valid_cycles=%0d required=0", ghosts);
    end
    checks++;
    if (cmp_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready in_ready=%b required=1", cmp_if.in_ready);
    end
  endtask

`ifdef FPCMP_MINMAX_EN
  task automatic test_minmax;
    do_op(NAN, N3, 2'b00, 4'd14);
    checks++;
    if (r_min !== N3 || r_max !== N3) begin
      errors++;
      $display("FAIL minmax_nan min=%h max=%h required %h", r_min, r_max, N3);
    end
    do_op(PZ, NZ, 2'b10, 4'd15);
    checks++;
    if (r_min !== PZ || r_max !== PZ) begin
      errors++;
      $display("FAIL minmax_zero min=%h max=%h required %h", r_min, r_max, PZ);
    end
    do_op(N1, P2, 2'b00, 4'd0);
    checks++;
    if (r_min !== N1 || r_max !== P2) begin
      errors++;
      $display("FAIL minmax_order min=%h max=%h required %h %h", r_min, r_max, N1, P2);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    P1   = mk(2'b01, 1'b0, 11'd1023, 9'd0);
    P2   = mk(2'b01, 1'b0, 11'd1024, 9'd0);
    N1   = mk(2'b01, 1'b1, 11'd1023, 9'd0);
    N2   = mk(2'b01, 1'b1, 11'd1024, 9'd0);
    N3   = mk(2'b01, 1'b1, 11'd1024, 9'd256);
    PZ   = mk(2'b00, 1'b0, 11'd0, 9'd0);
    NZ   = mk(2'b00, 1'b1, 11'd0, 9'd0);
    NAN  = mk(2'b11, 1'b0, 11'd5, 9'd3);
    PINF = mk(2'b10, 1'b0, 11'd0, 9'd0);
    NINF = mk(2'b10, 1'b1, 11'd0, 9'd0);
    test_reset();
    test_basic();
    test_zero();
    test_nan();
    test_negative();
    test_back_to_back();
    test_rst_mid();
`ifdef FPCMP_MINMAX_EN
    test_minmax();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
